// File: rtl/pipe_pkg.sv
// Shared state encoding and default sizing for the pipeline stage register.
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles, sticks at all ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic w_sat;

  assign w_sat = &count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && !w_sat)
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and backpressure counter.
// Define PIPE_STAGE_SKID_EN for a registered in_ready with a skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter int               CNT_W       = DEF_CNT_W
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  pipe_state_e      r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;

`ifdef PIPE_STAGE_SKID_EN
  logic             r_in_ready;
  logic [WIDTH-1:0] r_skid;

  // in_ready comes straight from a flop, so out_ready never reaches upstream.
  assign in_ready = r_in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= FLUSH_VALUE;
      r_skid      <= FLUSH_VALUE;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= FLUSH_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) begin
          r_state     <= ST_FULL;
          r_out_valid <= 1'b1;
          r_main      <= in_data;
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_state    <= ST_SKID;
            r_in_ready <= 1'b0;
            r_skid     <= in_data;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_SKID: if (w_out_fire) begin
          r_state    <= ST_FULL;
          r_in_ready <= 1'b1;
          r_main     <= r_skid;
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end
`else
  assign in_ready = out_ready | ~r_out_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main      <= FLUSH_VALUE;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_main      <= FLUSH_VALUE;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) begin
          r_state     <= ST_FULL;
          r_out_valid <= 1'b1;
          r_main      <= in_data;
        end
        ST_FULL: begin
          // in_fire in FULL implies out_fire here, so it is a straight reload.
          if (w_in_fire) begin
            r_main <= in_data;
          end else if (w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
`endif

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (r_out_valid & ~out_ready),
    .count (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; skid-specific steps follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int          WIDTH = 16;
  localparam int          CNT_W = 4;
  localparam logic [15:0] FV    = 16'hDEAD;

  logic             clock = 1'b0;
  logic             reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CNT_W-1:0] stall_cnt;
  int               checks = 0;
  int               failures = 0;

  pipe_stage_reg #(.WIDTH(WIDTH), .FLUSH_VALUE(FV), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, FV);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b0;

    // streaming 1,2,3
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = 16'd1; step();
    chk("stream_d1", out_data, 1);
    chk("stream_v1", out_valid, 1);
    in_data = 16'd2; step();
    chk("stream_d2", out_data, 2);
    chk("stream_v2", out_valid, 1);
    in_data = 16'd3; step();
    chk("stream_d3", out_data, 3);
    chk("stream_v3", out_valid, 1);
    in_valid = 1'b0; step();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold_data", out_data, 3);
    chk("stream_stall", stall_cnt, 0);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h000A; step();
    chk("skid_a_data", out_data, 16'h000A);
    chk("skid_a_rdy", in_ready, 1);
    in_data = 16'h000B; step();
    chk("skid_b_rdy", in_ready, 0);
    chk("skid_b_data", out_data, 16'h000A);
    chk("skid_b_valid", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("skid_emit_b", out_data, 16'h000B);
    chk("skid_emit_valid", out_valid, 1);
    chk("skid_emit_rdy", in_ready, 1);
    step();
    chk("skid_empty", out_valid, 0);
    chk("skid_cnt", stall_cnt, 1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0022; step();
    in_valid = 1'b0;
`else
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011; step();
    in_valid = 1'b0; #1;
    chk("comb_rdy_low", in_ready, 0);
    step();
    chk("hold_data", out_data, 16'h0011);
    chk("hold_cnt", stall_cnt, 1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0022; #1;
    chk("comb_rdy_high", in_ready, 1);
    step();
    chk("replace_data", out_data, 16'h0022);
    chk("replace_valid", out_valid, 1);
    chk("replace_cnt", stall_cnt, 1);
    out_ready = 1'b0; in_valid = 1'b0;
`endif

    // saturation from stall_cnt 1 with payload 0x22 held
    for (int i = 0; i < 10; i++) step();
    chk("sat_mid", stall_cnt, 11);
    for (int i = 0; i < 4; i++) step();
    chk("sat_reach", stall_cnt, 15);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_data", out_data, 16'h0022);

`ifdef PIPE_STAGE_SKID_EN
    in_valid = 1'b1; in_data = 16'h0066; step();
    chk("pre_flush_skid", in_ready, 0);
`endif
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0033; out_ready = 1'b1; step();
    chk("flush_valid", out_valid, 0);
    chk("flush_data", out_data, FV);
    chk("flush_rdy", in_ready, 1);
    chk("flush_cnt_kept", stall_cnt, 15);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("flush_dropped", out_valid, 0);
    chk("flush_dropped_data", out_data, FV);

    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0044; step();
    chk("pre_rst_data", out_data, 16'h0044);
`ifdef PIPE_STAGE_SKID_EN
    in_data = 16'h0055; step();
    chk("pre_rst_skid", in_ready, 0);
`endif
    reset = 1'b1; in_data = 16'h0077; step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_data", out_data, FV);
    chk("mid_rst_cnt", stall_cnt, 0);
    reset = 1'b0; in_valid = 1'b0; step();
    chk("post_rst_empty", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
